// File: rtl/speed_ctrl_pkg.sv
// Shared types for the speed controller: operand width, speed type and FSM states.
package speed_ctrl_pkg;

    localparam int SPEED_W = 20;

    typedef logic [SPEED_W-1:0] speed_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_WAIT,
        REPEAT,
        BLOCKED
    } state_t;

endpackage

// File: rtl/speed_controller_debounce.sv
// Active-low raw button -> 2-flop synchronizer -> stable-count debouncer.
// level is active-high (1 = pressed) and follows the input after STABLE_CYCLES of agreement.
module debounce #(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din_n,
    output logic level
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          pressed;

    assign pressed = ~sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= din_n;
            sync2 <= sync1;
            if (pressed != level) begin
                if (cnt == CNT_LAST) begin
                    level <= pressed;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/speed_controller.sv
// Push-button speed setter: debounced up/down presses step a saturating 20-bit
// speed with hold-to-auto-repeat; feeds clock_divider.speed.
module speed_controller
    import speed_ctrl_pkg::*;
#(
    parameter int BASE_SPEED      = 50000000,
    parameter int MIN_SPEED       = 50,
    parameter int MAX_SPEED       = 1000000,
    parameter int INIT_SPEED      = 1000,
    parameter int STEP            = 50,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up_n,
    input  logic               btn_down_n,
    output logic [SPEED_W-1:0] speed,
    output logic               at_min,
    output logic               at_max,
    output logic               changed
);

    if (MIN_SPEED <= 0 || STEP <= 0 || INIT_SPEED < MIN_SPEED || INIT_SPEED > MAX_SPEED ||
        longint'(MAX_SPEED) >= (64'd1 << SPEED_W) ||
        longint'(BASE_SPEED) >= longint'(MIN_SPEED) * (64'd1 << SPEED_W) ||
        DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("speed_controller: illegal parameter combination");
    end

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // After reset the debounced levels read "released" until a held button has
    // propagated through the debouncer; presses seen in that window are treated as held-through-reset.
    localparam int SETTLE   = DEBOUNCE_CYCLES + 3;
    localparam int SETTLE_W = $clog2(SETTLE + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE);

    localparam speed_t MIN_S  = speed_t'(MIN_SPEED);
    localparam speed_t MAX_S  = speed_t'(MAX_SPEED);
    localparam speed_t INIT_S = speed_t'(INIT_SPEED);
    localparam logic [SPEED_W:0] STEP_X     = (SPEED_W + 1)'(STEP);
    localparam logic [SPEED_W:0] MAX_X      = (SPEED_W + 1)'(MAX_SPEED);
    localparam logic [SPEED_W:0] MIN_STEP_X = (SPEED_W + 1)'(MIN_SPEED + STEP);

    logic up_lvl, dn_lvl;
    logic press_up, press_dn, press_both, held_same, settling;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               dir_up, dir_up_nxt;
    logic               step_req;
    logic [SETTLE_W-1:0] settle_cnt;

    logic [SPEED_W:0] up_sum, dn_diff;
    speed_t           up_val, dn_val, speed_nxt;

    debounce #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .din_n (btn_up_n),
        .level (up_lvl)
    );

    debounce #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk   (clk),
        .reset (reset),
        .din_n (btn_down_n),
        .level (dn_lvl)
    );

    assign press_up   = up_lvl & ~dn_lvl;
    assign press_dn   = dn_lvl & ~up_lvl;
    assign press_both = up_lvl & dn_lvl;
    assign held_same  = dir_up ? press_up : press_dn;
    assign settling   = (settle_cnt != SETTLE_LAST);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dir_up_nxt = dir_up;
        step_req   = 1'b0;
        case (state)
            IDLE: begin
                if (press_both || (settling && (press_up || press_dn))) begin
                    state_nxt = BLOCKED;
                end else if (press_up || press_dn) begin
                    step_req   = 1'b1;
                    dir_up_nxt = press_up;
                    cnt_nxt    = '0;
                    state_nxt  = HOLD_WAIT;
                end
            end
            HOLD_WAIT: begin
                if (held_same) begin
                    if (cnt == DELAY_LAST) begin
                        step_req  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (up_lvl || dn_lvl) begin
                    state_nxt = BLOCKED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REPEAT: begin
                if (held_same) begin
                    if (cnt == PERIOD_LAST) begin
                        step_req = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (up_lvl || dn_lvl) begin
                    state_nxt = BLOCKED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BLOCKED: begin
                if (!up_lvl && !dn_lvl) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating step evaluated one bit wider so neither direction can wrap.
    always_comb begin
        up_sum  = {1'b0, speed} + STEP_X;
        dn_diff = {1'b0, speed} - STEP_X;
        up_val  = (up_sum > MAX_X) ? MAX_S : up_sum[SPEED_W-1:0];
        dn_val  = ({1'b0, speed} < MIN_STEP_X) ? MIN_S : dn_diff[SPEED_W-1:0];
        speed_nxt = speed;
        if (step_req) begin
            speed_nxt = dir_up_nxt ? up_val : dn_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dir_up     <= 1'b1;
            settle_cnt <= '0;
            speed      <= INIT_S;
            changed    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dir_up  <= dir_up_nxt;
            speed   <= speed_nxt;
            changed <= (speed_nxt != speed);
            if (settling) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    assign at_min = (speed == MIN_S);
    assign at_max = (speed == MAX_S);

endmodule

// File: tb/tb_speed_controller.sv
// Bench for speed_controller: two instances (INIT 1000 and INIT 80) share the buttons;
// expectations come from hold-length arithmetic and a saturating step function.
module tb_speed_controller;
    import speed_ctrl_pkg::*;

    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int STP  = 50;
    localparam int MINS = 50;
    localparam int MAXS = 1200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic up_n = 1'b1;
    logic dn_n = 1'b1;

    logic [SPEED_W-1:0] speed_a, speed_b;
    logic at_min_a, at_max_a, changed_a;
    logic at_min_b, at_max_b, changed_b;

    int total = 0;
    int bad   = 0;
    int chg_a = 0;
    int chg_b = 0;
    int exp_a, exp_b, pulses_a, pulses_b, base_a, base_b;

    speed_controller #(
        .MIN_SPEED(MINS), .MAX_SPEED(MAXS), .INIT_SPEED(1000), .STEP(STP),
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_a (
        .clk(clk), .reset(reset), .btn_up_n(up_n), .btn_down_n(dn_n),
        .speed(speed_a), .at_min(at_min_a), .at_max(at_max_a), .changed(changed_a)
    );

    speed_controller #(
        .MIN_SPEED(MINS), .MAX_SPEED(MAXS), .INIT_SPEED(80), .STEP(STP),
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_b (
        .clk(clk), .reset(reset), .btn_up_n(up_n), .btn_down_n(dn_n),
        .speed(speed_b), .at_min(at_min_b), .at_max(at_max_b), .changed(changed_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (changed_a === 1'b1) chg_a++;
        if (changed_b === 1'b1) chg_b++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int step_val(input int s, input bit up);
        if (up) return (s + STP > MAXS) ? MAXS : s + STP;
        return (s < MINS + STP) ? MINS : s - STP;
    endfunction

    // Steps produced by a clean raw hold of L cycles starting from IDLE.
    function automatic int hold_steps(input int len);
        if (len < DEB) return 0;
        if (len - 1 < RD) return 1;
        return 2 + (len - 1 - RD) / RP;
    endfunction

    task automatic model_hold(input bit up, input int len);
        int n;
        int nx;
        n = hold_steps(len);
        for (int i = 0; i < n; i++) begin
            nx = step_val(exp_a, up);
            if (nx != exp_a) pulses_a++;
            exp_a = nx;
            nx = step_val(exp_b, up);
            if (nx != exp_b) pulses_b++;
            exp_b = nx;
        end
    endtask

    task automatic press(input bit up, input int len, input int gap);
        if (up) up_n = 1'b0; else dn_n = 1'b0;
        tick(len);
        up_n = 1'b1;
        dn_n = 1'b1;
        tick(gap);
        model_hold(up, len);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(10);
        exp_a = 1000;
        exp_b = 80;
        pulses_a = 0;
        pulses_b = 0;
        base_a = chg_a;
        base_b = chg_b;
    endtask

    initial begin
        bit up;
        int len;

        // 1. reset and idle
        tick(2);
        reset = 1'b0;
        tick(50);
        check("rst_speed", speed_a, 1000);
        check("rst_at_min", at_min_a, 0);
        check("rst_at_max", at_max_a, 0);
        check("rst_changed_cnt", chg_a, 0);
        check("rst_speed_b", speed_b, 80);
        exp_a = 1000; exp_b = 80; pulses_a = 0; pulses_b = 0; base_a = chg_a; base_b = chg_b;

        // 2. bounce rejected, clean pulse gives one step with 2+DEB+1 latency
        for (int i = 0; i < 3; i++) begin
            up_n = 1'b0; tick(2);
            up_n = 1'b1; tick(2);
        end
        tick(20);
        check("bounce_speed", speed_a, 1000);
        check("bounce_pulses", chg_a - base_a, 0);
        up_n = 1'b0;
        tick(6);
        check("lat_early", speed_a, 1000);
        tick(1);
        check("lat_step", speed_a, 1050);
        check("lat_changed_hi", changed_a, 1);
        tick(1);
        check("lat_changed_lo", changed_a, 0);
        tick(2);
        up_n = 1'b1;
        tick(20);
        model_hold(1'b1, 10);
        check("tap_speed", speed_a, exp_a);
        check("tap_pulses", chg_a - base_a, pulses_a);
        check("tap_speed_b", speed_b, exp_b);

        // 3. hold to auto-repeat, saturate at MAX
        do_reset();
        up_n = 1'b0;
        tick(7);
        check("rep_first", speed_a, 1050);
        tick(20);
        check("rep_second", speed_a, 1100);
        tick(5);
        check("rep_third", speed_a, 1150);
        tick(5);
        check("rep_fourth", speed_a, 1200);
        check("rep_at_max", at_max_a, 1);
        tick(43);
        up_n = 1'b1;
        tick(20);
        model_hold(1'b1, 80);
        check("sat_speed", speed_a, 1200);
        check("sat_pulses", chg_a - base_a, 4);
        check("sat_speed_b", speed_b, exp_b);
        check("sat_pulses_b", chg_b - base_b, pulses_b);

        // 4. down taps clamp at MIN
        do_reset();
        press(1'b0, 10, 20);
        check("min_first", speed_b, 50);
        check("min_at_min", at_min_b, 1);
        press(1'b0, 10, 20);
        check("min_clamped", speed_b, 50);
        check("min_pulses", chg_b - base_b, 1);
        check("min_at_min2", at_min_b, 1);
        check("min_speed_a", speed_a, 900);

        // 5. second button blocks stepping until both released
        do_reset();
        up_n = 1'b0;
        tick(7);
        check("blk_first", speed_a, 1050);
        tick(3);
        dn_n = 1'b0;
        tick(30);
        check("blk_both", speed_a, 1050);
        dn_n = 1'b1;
        tick(30);
        check("blk_up_only", speed_a, 1050);
        up_n = 1'b1;
        tick(15);
        up_n = 1'b0;
        tick(7);
        check("blk_resume", speed_a, 1100);
        up_n = 1'b1;
        tick(20);
        check("blk_pulses", chg_a - base_a, 2);
        check("blk_speed_b", speed_b, 180);

        // 6. reset during REPEAT with button held
        do_reset();
        up_n = 1'b0;
        tick(40);
        check("mid_pre", speed_a, 1200);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_reset_speed", speed_a, 1000);
        check("mid_reset_changed", changed_a, 0);
        base_a = chg_a;
        tick(40);
        check("mid_held_speed", speed_a, 1000);
        check("mid_held_pulses", chg_a - base_a, 0);
        up_n = 1'b1;
        tick(15);
        exp_a = 1000; exp_b = 80; pulses_a = 0; pulses_b = 0;
        press(1'b1, 10, 20);
        check("mid_repress", speed_a, exp_a);
        check("mid_repress_b", speed_b, exp_b);

        // random clean holds against the hold-length model
        do_reset();
        for (int k = 0; k < 24; k++) begin
            up  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 70);
            press(up, len, 15);
            check("rnd_speed_a", speed_a, exp_a);
            check("rnd_speed_b", speed_b, exp_b);
        end
        check("rnd_pulses_a", chg_a - base_a, pulses_a);
        check("rnd_pulses_b", chg_b - base_b, pulses_b);
        check("rnd_at_min_a", at_min_a, (exp_a == MINS) ? 1 : 0);
        check("rnd_at_max_a", at_max_a, (exp_a == MAXS) ? 1 : 0);
        check("rnd_at_min_b", at_min_b, (exp_b == MINS) ? 1 : 0);
        check("rnd_at_max_b", at_max_b, (exp_b == MAXS) ? 1 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
